dw_fmap_writer: RTL

- Consumer end of the depthwise stage's output stream: accepts one requantized int8 pixel per handshake, in raster order, for a single channel plane.
- Scatters each pixel into the activation SRAM in HWC-interleaved layout through a single write port with back-pressure.
- Tracks the output geometry from the same image configuration the stage uses, and pulses done after the last write is accepted.

---
 rtl/dw_pkg.sv | 8 +
 rtl/fmap_raster_cnt.sv | 28 ++
 rtl/dw_fmap_writer.sv | 102 ++++++++++
 3 files changed

// File: rtl/dw_pkg.sv
// dw_pkg: shared state type, stride limit and output-size helper for the depthwise stage
package dw_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} wr_state_t;
  localparam int STRIDE_MAX = 2;
  function automatic logic [15:0] out_dim(input logic [15:0] dim, input logic [15:0] stride);
    return stride == 16'd2 ? 16'((17'(dim) + 17'd1) >> 1) : dim;
  endfunction
endpackage

// File: rtl/fmap_raster_cnt.sv
// fmap_raster_cnt: raster-order row/col counter flagging the last pixel of a rows x cols plane
module fmap_raster_cnt #(
  parameter int ROW_W = 8,
  parameter int COL_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [ROW_W-1:0] rows,
  input  logic [COL_W-1:0] cols,
  output logic             last
);
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             col_end;
  assign col_end = col == cols - COL_W'(1);
  assign last = col_end && row == rows - ROW_W'(1);
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      col <= col_end ? '0 : col + COL_W'(1);
      row <= col_end ? row + ROW_W'(1) : row;
    end
  end
endmodule

// File: rtl/dw_fmap_writer.sv
// dw_fmap_writer: scatters a raster int8 channel plane into HWC-interleaved SRAM with back-pressure.
// Optional write-stall counter enabled by DW_FMAP_WR_STALL_CNT_EN.
module dw_fmap_writer
  import dw_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_IMG_W = 224,
  parameter int MAX_IMG_H = 224,
  parameter int ADDR_W    = 20
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [$clog2(MAX_IMG_H)-1:0] cfg_img_h,
  input  logic [$clog2(MAX_IMG_W)-1:0] cfg_img_w,
  input  logic [$clog2(MAX_IMG_H)-1:0] cfg_stride,
  input  logic [ADDR_W-1:0]            cfg_base_addr,
  input  logic [ADDR_W-1:0]            cfg_ch_stride,
  input  logic [ADDR_W-1:0]            cfg_ch_idx,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         mem_wr_en,
  input  logic                         mem_wr_ready,
  output logic [ADDR_W-1:0]            mem_wr_addr,
  output logic [DATA_W-1:0]            mem_wr_data,
  output logic                         busy,
  output logic                         done,
  output logic                         err_cfg,
  output logic [31:0]                  stall_cycles
);
  localparam int HW = $clog2(MAX_IMG_H);
  localparam int WW = $clog2(MAX_IMG_W);
  wr_state_t     state;
  logic [HW-1:0] oh_q;
  logic [WW-1:0] ow_q;
  logic [ADDR_W-1:0] step_q, addr;
  logic accept, last, cfg_ok, launch;
  assign cfg_ok = cfg_img_h != '0 && cfg_img_w != '0 && cfg_stride != '0 && 32'(cfg_stride) <= STRIDE_MAX;
  assign launch = start && state == IDLE;
  assign in_ready = state == RUN && (!mem_wr_en || mem_wr_ready);
  assign accept = in_valid && in_ready;
  assign busy = state == RUN || state == DRAIN;
  fmap_raster_cnt #(.ROW_W(HW), .COL_W(WW)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (launch),
    .inc  (accept),
    .rows (oh_q),
    .cols (ow_q),
    .last (last)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      oh_q        <= '0;
      ow_q        <= '0;
      step_q      <= '0;
      addr        <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      done        <= 1'b0;
      err_cfg     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (mem_wr_en && mem_wr_ready) mem_wr_en <= 1'b0;
      // an accept in the same cycle as a drained write replaces it without a bubble
      if (accept) begin
        mem_wr_en   <= 1'b1;
        mem_wr_addr <= addr;
        mem_wr_data <= in_data;
        addr        <= addr + step_q;
      end
      case (state)
        IDLE: if (start) begin
          oh_q    <= HW'(out_dim(16'(cfg_img_h), 16'(cfg_stride)));
          ow_q    <= WW'(out_dim(16'(cfg_img_w), 16'(cfg_stride)));
          step_q  <= cfg_ch_stride;
          addr    <= cfg_base_addr + cfg_ch_idx;
          err_cfg <= !cfg_ok;
          done    <= !cfg_ok;
          state   <= cfg_ok ? RUN : DONE;
        end
        RUN: if (accept && last) state <= DRAIN;
        DRAIN: if (mem_wr_ready) begin
          done  <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef DW_FMAP_WR_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || launch) stall_cycles <= '0;
    else if (busy && mem_wr_en && !mem_wr_ready && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
  end
`else
  assign stall_cycles = '0;
`endif
endmodule
